// File: rtl/router_param.sv
// Parameterised wormhole router: per-input FIFO and IDLE/REQ/XFER FSM, and per-output
// round-robin arbiter whose grant is held from the head flit through the tail flit.
module router_param #(
    parameter int unsigned NUM_PORTS  = 5,
    parameter int unsigned DATA_WIDTH = 70,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned DEST_W     = 4,
    localparam int unsigned PORT_W    = $clog2(NUM_PORTS)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] in_data,
    input  logic [NUM_PORTS-1:0]            in_val,
    output logic [NUM_PORTS-1:0]            in_ack,
    output logic [NUM_PORTS*DATA_WIDTH-1:0] out_data,
    output logic [NUM_PORTS-1:0]            out_val,
    input  logic [NUM_PORTS-1:0]            out_ack,
    input  logic                            cfg_we,
    input  logic [DEST_W-1:0]               cfg_dest,
    input  logic [PORT_W-1:0]               cfg_port,
    output logic [15:0]                     drop_cnt
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned TBL_N = 2 ** DEST_W;
    localparam int unsigned HEAD  = DATA_WIDTH - 1;
    localparam int unsigned TAIL  = DATA_WIDTH - 2;

    typedef enum logic [1:0] {StIdle, StReq, StXfer} in_state_e;

    logic [DATA_WIDTH-1:0] mem_q [NUM_PORTS][FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q [NUM_PORTS];
    logic [PTR_W-1:0]      wr_ptr_d [NUM_PORTS];
    logic [PTR_W-1:0]      rd_ptr_q [NUM_PORTS];
    logic [PTR_W-1:0]      rd_ptr_d [NUM_PORTS];
    logic [CNT_W-1:0]      cnt_q    [NUM_PORTS];
    logic [CNT_W-1:0]      cnt_d    [NUM_PORTS];
    in_state_e             state_q  [NUM_PORTS];
    in_state_e             state_d  [NUM_PORTS];
    logic [PORT_W-1:0]     tgt_q    [NUM_PORTS];
    logic [PORT_W-1:0]     tgt_d    [NUM_PORTS];
    logic [PORT_W-1:0]     gnt_idx_q [NUM_PORTS];
    logic [PORT_W-1:0]     gnt_idx_d [NUM_PORTS];
    logic [PORT_W-1:0]     rr_q     [NUM_PORTS];
    logic [PORT_W-1:0]     rr_d     [NUM_PORTS];
    logic [PORT_W-1:0]     tbl_q    [TBL_N];
    logic [PORT_W-1:0]     tbl_d    [TBL_N];
    logic [NUM_PORTS-1:0]  gnt_vld_q, gnt_vld_d;
    logic [15:0]           drop_q, drop_d;
    logic                  rdy_q, rdy_d;

    logic [DATA_WIDTH-1:0] front [NUM_PORTS];
    logic [NUM_PORTS-1:0]  req   [NUM_PORTS];
    logic [NUM_PORTS-1:0]  nempty, full, push, pop, fwd_pop, drop_pop, fwd_pop_o, gnt_new;
    logic [PORT_W-1:0]     cand;
    logic [3:0]            drop_sum;
    logic [16:0]           drop_inc;

    // FIFO status and ingress handshake; rdy_q keeps in_ack low until the first edge out of reset
    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            front[i]  = mem_q[i][rd_ptr_q[i]];
            nempty[i] = (cnt_q[i] != '0);
            full[i]   = (cnt_q[i] == CNT_W'(FIFO_DEPTH));
        end
        in_ack = {NUM_PORTS{rdy_q}} & ~full;
        push   = in_val & in_ack;
        rdy_d  = 1'b1;
    end

    // Egress datapath
    always_comb begin
        out_val   = '0;
        out_data  = '0;
        fwd_pop_o = '0;
        for (int o = 0; o < NUM_PORTS; o++) begin
            if (gnt_vld_q[o] && nempty[gnt_idx_q[o]]) begin
                out_val[o] = 1'b1;
                out_data[o*DATA_WIDTH +: DATA_WIDTH] = front[gnt_idx_q[o]];
            end
            fwd_pop_o[o] = out_val[o] & out_ack[o];
        end
    end

    always_comb begin
        fwd_pop  = '0;
        drop_pop = '0;
        drop_sum = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            for (int o = 0; o < NUM_PORTS; o++) begin
                if (fwd_pop_o[o] && gnt_idx_q[o] == PORT_W'(i)) fwd_pop[i] = 1'b1;
                req[o][i] = (state_q[i] == StReq) && (tgt_q[i] == PORT_W'(o));
            end
            drop_pop[i] = (state_q[i] == StIdle) && nempty[i] && !front[i][HEAD];
            drop_sum    = drop_sum + 4'(drop_pop[i]);
        end
        pop      = fwd_pop | drop_pop;
        drop_inc = 17'(drop_q) + 17'(drop_sum);
        drop_d   = (drop_inc > 17'h0FFFF) ? 16'hFFFF : drop_inc[15:0];
    end

    // Round-robin arbiters; a grant stays until its tail flit leaves
    always_comb begin
        gnt_vld_d = gnt_vld_q;
        gnt_idx_d = gnt_idx_q;
        rr_d      = rr_q;
        gnt_new   = '0;
        cand      = '0;
        for (int o = 0; o < NUM_PORTS; o++) begin
            if (gnt_vld_q[o]) begin
                if (fwd_pop_o[o] && front[gnt_idx_q[o]][TAIL]) gnt_vld_d[o] = 1'b0;
            end else begin
                for (int k = 0; k < NUM_PORTS; k++) begin
                    cand = PORT_W'((32'(rr_q[o]) + 32'(k)) % NUM_PORTS);
                    if (!gnt_new[o] && req[o][cand]) begin
                        gnt_new[o]   = 1'b1;
                        gnt_vld_d[o] = 1'b1;
                        gnt_idx_d[o] = cand;
                        rr_d[o]      = PORT_W'((32'(cand) + 1) % NUM_PORTS);
                    end
                end
            end
        end
    end

    // Input FSMs and FIFO pointers
    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            state_d[i]  = state_q[i];
            tgt_d[i]    = tgt_q[i];
            wr_ptr_d[i] = wr_ptr_q[i] + PTR_W'(push[i]);
            rd_ptr_d[i] = rd_ptr_q[i] + PTR_W'(pop[i]);
            cnt_d[i]    = cnt_q[i];
            case ({push[i], pop[i]})
                2'b10:   cnt_d[i] = cnt_q[i] + CNT_W'(1);
                2'b01:   cnt_d[i] = cnt_q[i] - CNT_W'(1);
                default: cnt_d[i] = cnt_q[i];
            endcase
            unique case (state_q[i])
                StIdle: begin
                    if (nempty[i] && front[i][HEAD]) begin
                        tgt_d[i]   = tbl_q[front[i][DEST_W-1:0]];
                        state_d[i] = StReq;
                    end
                end
                StReq: begin
                    if (gnt_new[tgt_q[i]] && gnt_idx_d[tgt_q[i]] == PORT_W'(i)) begin
                        state_d[i] = StXfer;
                    end
                end
                StXfer: begin
                    if (fwd_pop[i] && front[i][TAIL]) state_d[i] = StIdle;
                end
                default: state_d[i] = StIdle;
            endcase
        end
    end

    always_comb begin
        tbl_d = tbl_q;
        if (cfg_we && (32'(cfg_port) < NUM_PORTS)) tbl_d[cfg_dest] = cfg_port;
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (push[i]) mem_q[i][wr_ptr_q[i]] <= in_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                wr_ptr_q[i]  <= '0;
                rd_ptr_q[i]  <= '0;
                cnt_q[i]     <= '0;
                state_q[i]   <= StIdle;
                tgt_q[i]     <= '0;
                gnt_idx_q[i] <= '0;
                rr_q[i]      <= '0;
            end
            for (int t = 0; t < TBL_N; t++) tbl_q[t] <= PORT_W'(t % NUM_PORTS);
            gnt_vld_q <= '0;
            drop_q    <= '0;
            rdy_q     <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            cnt_q     <= cnt_d;
            state_q   <= state_d;
            tgt_q     <= tgt_d;
            gnt_idx_q <= gnt_idx_d;
            rr_q      <= rr_d;
            tbl_q     <= tbl_d;
            gnt_vld_q <= gnt_vld_d;
            drop_q    <= drop_d;
            rdy_q     <= rdy_d;
        end
    end

    assign drop_cnt = drop_q;

endmodule

// File: tb/tb_router_param.sv
// Scoreboard bench for router_param: expected flits are queued per output port and
// checked in order as the router emits them.
`timescale 1ns/1ps
module tb_router_param;

    localparam int N  = 5;
    localparam int DW = 70;
    localparam int DESTW = 4;
    localparam int PW = 3;

    typedef logic [DW-1:0] flit_t;

    logic              clk = 1'b0;
    logic              rst;
    wire  [N*DW-1:0]   in_data;
    logic [N-1:0]      in_val;
    logic [N-1:0]      in_ack;
    logic [N*DW-1:0]   out_data;
    logic [N-1:0]      out_val;
    logic [N-1:0]      out_ack;
    logic              cfg_we;
    logic [DESTW-1:0]  cfg_dest;
    logic [PW-1:0]     cfg_port;
    logic [15:0]       drop_cnt;

    flit_t tb_data [N];
    flit_t exp_q [N][$];
    int    n_checks = 0;
    int    n_fail = 0;
    bit    done = 1'b0;

    for (genvar g = 0; g < N; g++) begin : g_pack
        assign in_data[g*DW +: DW] = tb_data[g];
    end

    always #5 clk = ~clk;

    router_param dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_val(in_val), .in_ack(in_ack),
        .out_data(out_data), .out_val(out_val), .out_ack(out_ack), .cfg_we(cfg_we),
        .cfg_dest(cfg_dest), .cfg_port(cfg_port), .drop_cnt(drop_cnt)
    );

    function automatic flit_t mk(input bit h, input bit t, input int dest, input int unsigned pay);
        flit_t f;
        f = '0;
        f[DW-1] = h;
        f[DW-2] = t;
        f[DESTW-1:0] = DESTW'(dest);
        f[DESTW +: 32] = pay;
        return f;
    endfunction

    task automatic drive_flit(input int p, input flit_t f, output bit ok);
        ok = 1'b0;
        tb_data[p] = f;
        in_val[p] = 1'b1;
        for (int c = 0; c < 200 && !ok; c++) begin
            @(negedge clk);
            ok = in_ack[p];
            @(posedge clk);
            #1;
        end
        in_val[p] = 1'b0;
    endtask

    task automatic cfg_write(input int dest, input int port);
        @(posedge clk); #1;
        cfg_we = 1'b1;
        cfg_dest = DESTW'(dest);
        cfg_port = PW'(port);
        @(posedge clk); #1;
        cfg_we = 1'b0;
    endtask

    task automatic wait_drain(input int o);
        for (int c = 0; c < 200 && exp_q[o].size() != 0; c++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (out_val !== '0) begin n_fail++; $display("FAIL reset_out_val got=%b required=0", out_val); end
        n_checks++; if (in_ack !== '0) begin n_fail++; $display("FAIL reset_in_ack got=%b required=0", in_ack); end
        n_checks++; if (out_data !== '0) begin n_fail++; $display("FAIL reset_out_data got=%h required=0", out_data); end
        n_checks++; if (drop_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_drop_cnt got=%0d required=0", drop_cnt); end
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_checks++; if (in_ack !== '0) begin n_fail++; $display("FAIL ack_before_edge got=%b required=0", in_ack); end
        @(posedge clk); #1;
        n_checks++; if (in_ack !== 5'h1f) begin n_fail++; $display("FAIL ack_after_edge got=%b required=11111", in_ack); end
    endtask

    task automatic test_route_latency();
        flit_t f [3];
        logic [5:0] seen;
        cfg_write(3, 2);
        cfg_write(3, 7);  // out-of-range port, must be ignored
        for (int i = 0; i < 3; i++) begin
            f[i] = mk(i == 0, i == 2, 3, 32'h1100 + i);
            exp_q[2].push_back(f[i]);
        end
        seen = '0;
        tb_data[1] = f[0];
        in_val[1] = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            seen[c] = out_val[2];
            if (c < 2) tb_data[1] = f[c+1];
            else if (c == 2) in_val[1] = 1'b0;
        end
        n_checks++; if (seen !== 6'b011100) begin n_fail++; $display("FAIL latency_profile got=%b required=011100", seen); end
        wait_drain(2);
        n_checks++; if (exp_q[2].size() != 0) begin n_fail++; $display("FAIL route_drain got=%0d left required=0", exp_q[2].size()); end
    endtask

    task automatic test_contention();
        bit ok1, ok3, ok4;
        for (int i = 0; i < 3; i++) begin
            int p;
            p = (i == 0) ? 1 : (i == 1) ? 3 : 4;
            exp_q[0].push_back(mk(1, 0, 0, 32'h2000 + p));
            exp_q[0].push_back(mk(0, 1, 0, 32'h2100 + p));
        end
        fork
            begin bit a, b; drive_flit(1, mk(1, 0, 0, 32'h2001), a); drive_flit(1, mk(0, 1, 0, 32'h2101), b); ok1 = a & b; end
            begin bit a, b; drive_flit(3, mk(1, 0, 0, 32'h2003), a); drive_flit(3, mk(0, 1, 0, 32'h2103), b); ok3 = a & b; end
            begin bit a, b; drive_flit(4, mk(1, 0, 0, 32'h2004), a); drive_flit(4, mk(0, 1, 0, 32'h2104), b); ok4 = a & b; end
        join
        n_checks++; if (!(ok1 & ok3 & ok4)) begin n_fail++; $display("FAIL contention_accept got=%b%b%b required=111", ok1, ok3, ok4); end
        wait_drain(0);
        n_checks++; if (exp_q[0].size() != 0) begin n_fail++; $display("FAIL contention_drain got=%0d left required=0", exp_q[0].size()); end
    endtask

    task automatic test_backpressure();
        flit_t f [6];
        int acc;
        bit a;
        acc = 0;
        out_ack[2] = 1'b0;
        for (int i = 0; i < 6; i++) begin
            f[i] = mk(i == 0, i == 5, 2, 32'h3300 + i);
            exp_q[2].push_back(f[i]);
        end
        tb_data[1] = f[0];
        in_val[1] = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk); a = in_ack[1];
            @(posedge clk); #1;
            if (a) begin acc++; if (acc < 6) tb_data[1] = f[acc]; else in_val[1] = 1'b0; end
        end
        n_checks++; if (acc != 4) begin n_fail++; $display("FAIL bp_accepted got=%0d required=4", acc); end
        n_checks++; if (in_ack[1] !== 1'b0) begin n_fail++; $display("FAIL bp_in_ack got=%b required=0", in_ack[1]); end
        out_ack[2] = 1'b1;
        for (int c = 0; c < 50 && acc < 6; c++) begin
            @(negedge clk); a = in_ack[1];
            @(posedge clk); #1;
            if (a) begin acc++; if (acc < 6) tb_data[1] = f[acc]; else in_val[1] = 1'b0; end
        end
        in_val[1] = 1'b0;
        n_checks++; if (acc != 6) begin n_fail++; $display("FAIL bp_total got=%0d required=6", acc); end
        wait_drain(2);
        n_checks++; if (exp_q[2].size() != 0) begin n_fail++; $display("FAIL bp_drain got=%0d left required=0", exp_q[2].size()); end
    endtask

    task automatic test_drop();
        bit ok;
        logic [N-1:0] seen;
        seen = '0;
        drive_flit(2, mk(0, 0, 1, 32'h4400), ok);
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            seen = seen | out_val;
        end
        n_checks++; if (seen !== '0) begin n_fail++; $display("FAIL drop_no_output got=%b required=0", seen); end
        n_checks++; if (drop_cnt !== 16'd1) begin n_fail++; $display("FAIL drop_cnt got=%0d required=1", drop_cnt); end
        exp_q[0].push_back(mk(1, 1, 0, 32'h4401));
        drive_flit(2, mk(1, 1, 0, 32'h4401), ok);
        wait_drain(0);
        n_checks++; if (exp_q[0].size() != 0) begin n_fail++; $display("FAIL single_flit got=%0d left required=0", exp_q[0].size()); end
        n_checks++; if (drop_cnt !== 16'd1) begin n_fail++; $display("FAIL drop_cnt_after got=%0d required=1", drop_cnt); end
    endtask

    task automatic test_table_rewrite();
        bit ok;
        flit_t f [4];
        for (int i = 0; i < 4; i++) begin
            f[i] = mk(i == 0, i == 3, 5, 32'h5500 + i);
            exp_q[0].push_back(f[i]);
        end
        drive_flit(3, f[0], ok);
        drive_flit(3, f[1], ok);
        cfg_write(5, 4);
        drive_flit(3, f[2], ok);
        drive_flit(3, f[3], ok);
        exp_q[4].push_back(mk(1, 0, 5, 32'h5600));
        exp_q[4].push_back(mk(0, 1, 5, 32'h5601));
        drive_flit(3, mk(1, 0, 5, 32'h5600), ok);
        drive_flit(3, mk(0, 1, 5, 32'h5601), ok);
        wait_drain(0);
        wait_drain(4);
        n_checks++; if (exp_q[0].size() != 0) begin n_fail++; $display("FAIL rewrite_old_port got=%0d left required=0", exp_q[0].size()); end
        n_checks++; if (exp_q[4].size() != 0) begin n_fail++; $display("FAIL rewrite_new_port got=%0d left required=0", exp_q[4].size()); end
    endtask

    task automatic test_reset_mid();
        bit ok, hit;
        logic [N-1:0] seen;
        out_ack[2] = 1'b0;
        hit = 1'b0;
        seen = '0;
        drive_flit(1, mk(1, 0, 2, 32'h6600), ok);
        drive_flit(1, mk(0, 0, 2, 32'h6601), ok);
        for (int c = 0; c < 20 && !hit; c++) begin
            @(posedge clk); #1;
            hit = out_val[2];
        end
        n_checks++; if (!hit) begin n_fail++; $display("FAIL mid_out_val got=0 required=1"); end
        #2;
        rst = 1'b0;
        #1;
        n_checks++; if (out_val !== '0) begin n_fail++; $display("FAIL rst_out_val got=%b required=0", out_val); end
        n_checks++; if (out_data !== '0) begin n_fail++; $display("FAIL rst_out_data got=%h required=0", out_data); end
        n_checks++; if (in_ack !== '0) begin n_fail++; $display("FAIL rst_in_ack got=%b required=0", in_ack); end
        exp_q[2].delete();
        @(negedge clk);
        rst = 1'b1;
        out_ack[2] = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            seen = seen | out_val;
        end
        n_checks++; if (seen !== '0) begin n_fail++; $display("FAIL post_rst_idle got=%b required=0", seen); end
        n_checks++; if (drop_cnt !== 16'd0) begin n_fail++; $display("FAIL post_rst_drop got=%0d required=0", drop_cnt); end
        n_checks++; if (in_ack !== 5'h1f) begin n_fail++; $display("FAIL post_rst_ack got=%b required=11111", in_ack); end
        exp_q[2].push_back(mk(1, 1, 2, 32'h6700));
        drive_flit(1, mk(1, 1, 2, 32'h6700), ok);
        wait_drain(2);
        n_checks++; if (exp_q[2].size() != 0) begin n_fail++; $display("FAIL post_rst_pkt got=%0d left required=0", exp_q[2].size()); end
    endtask

    initial begin
        in_val = '0;
        out_ack = '1;
        cfg_we = 1'b0;
        cfg_dest = '0;
        cfg_port = '0;
        for (int i = 0; i < N; i++) tb_data[i] = '0;
        fork
            begin
                test_reset();
                test_route_latency();
                test_contention();
                test_backpressure();
                test_drop();
                test_table_rewrite();
                test_reset_mid();
                repeat (3) @(posedge clk);
                done = 1'b1;
            end
            begin : monitor
                int cyc;
                flit_t e;
                cyc = 0;
                while (!done) begin
                    @(negedge clk);
                    cyc++;
                    if (cyc > 20000) begin
                        n_fail++;
                        $display("FAIL watchdog got=%0d cycles required=<20000", cyc);
                        $fatal(1, "watchdog expired");
                    end
                    if (rst === 1'b1) begin
                        for (int o = 0; o < N; o++) begin
                            if (out_val[o] && out_ack[o]) begin
                                n_checks++;
                                if (exp_q[o].size() == 0) begin
                                    n_fail++;
                                    $display("FAIL unexpected_flit port=%0d got=%h required=none", o, out_data[o*DW +: DW]);
                                end else begin
                                    e = exp_q[o].pop_front();
                                    if (out_data[o*DW +: DW] !== e) begin
                                        n_fail++;
                                        $display("FAIL flit_data port=%0d got=%h required=%h", o, out_data[o*DW +: DW], e);
                                    end
                                end
                            end
                        end
                    end
                end
            end
        join
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
